// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_deserializer
//  Brief    : Oversampled UART receive front end. It detects the start bit, shifts
//             the data bits in LSB-first and opens a stop-bit window for the checker.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       RX_in,
    output logic [7:0] RX_DATA,
    output logic       check_stop,
    output logic       frame_done,
    output logic       stop_sample,
    output logic       start_error,
    output logic       rx_busy
);

    localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SHIFT = 8 - DATA_BITS;

    localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] tick_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [6:0]       shreg;

    logic cnt_clr;
    logic cnt_inc;
    logic idx_clr;
    logic idx_inc;
    logic shift_en;
    logic load_data;
    logic done;
    logic false_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        shift_en    = 1'b0;
        load_data   = 1'b0;
        done        = 1'b0;
        false_start = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_clr    = 1'b1;
                        state_next = START;
                    end
                end
                START: begin
                    if (tick_cnt == MID_START) begin
                        if (rx_s) begin
                            false_start = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            cnt_clr    = 1'b1;
                            idx_clr    = 1'b1;
                            state_next = DATA;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == MID_BIT) begin
                        shift_en = 1'b1;
                        cnt_clr  = 1'b1;
                        idx_inc  = 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            load_data  = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == MID_BIT) begin
                        done       = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Sync flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            RX_DATA     <= '0;
            check_stop  <= 1'b0;
            frame_done  <= 1'b0;
            stop_sample <= 1'b0;
            start_error <= 1'b0;
        end else begin
            if (cnt_clr) begin
                tick_cnt <= '0;
            end else if (cnt_inc) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[6:1]};
            end
            // Last bit goes straight in with the first seven, aligned to bit 0.
            if (load_data) begin
                RX_DATA <= {rx_s, shreg} >> SHIFT;
            end
            check_stop  <= (state == STOP) && (state_next == STOP);
            frame_done  <= done;
            start_error <= false_start;
            if (done) begin
                stop_sample <= rx_s;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_deserializer
//  Brief    : Directed frame vectors plus hand-written corner sequences for the
//             UART receive deserializer (OVERSAMPLE=16, one tick every 4 clocks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_line = 1'b1;
    logic [7:0] rx_data;
    logic       check_stop;
    logic       frame_done;
    logic       stop_sample;
    logic       start_error;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx_deserializer #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .RX_in       (rx_line),
        .RX_DATA     (rx_data),
        .check_stop  (check_stop),
        .frame_done  (frame_done),
        .stop_sample (stop_sample),
        .start_error (start_error),
        .rx_busy     (rx_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         fd_cnt    = 0;
    int         se_cnt    = 0;
    int         cs_ticks  = 0;
    int         unstable  = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       last_stop = 1'b0;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt    = fd_cnt + 1;
            last_data = rx_data;
            last_stop = stop_sample;
        end
        if (start_error) se_cnt = se_cnt + 1;
        if (sample_tick && check_stop) cs_ticks = cs_ticks + 1;
        if (check_stop && (rx_data != prev_data)) unstable = unstable + 1;
        prev_data = rx_data;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; drives the line and one tick, returns at posedge+1 four clocks later.
    task automatic one_tick(input logic rx);
        rx_line     = rx;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic rx);
        repeat (n) one_tick(rx);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_at);
        int   t;
        logic val;
        logic [7:0] held;
        t = 0;
        for (int seg = 0; seg < 10; seg++) begin
            val = (seg == 0) ? 1'b0 : (seg == 9) ? stop : d[seg-1];
            for (int k = 0; k < 16; k++) begin
                one_tick(val);
                if (t == gap_at) begin
                    held = rx_data;
                    repeat (50) @(posedge clk);
                    #1;
                    check("gap_busy", rx_busy, 1);
                    check("gap_data_hold", rx_data, held);
                    check("gap_no_check_stop", check_stop, 0);
                end
                t++;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_stop;
        int         exp_se;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fd0;
        int se0;
        int cs0;

        // A low stop bit is still low when IDLE re-arms, so it triggers one false start.
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b0, 1};
        vecs[2] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 0};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_check_stop", check_stop, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_stop_sample", stop_sample, 0);
        check("rst_start_error", start_error, 0);
        check("rst_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ticks(4, 1'b1);

        for (int i = 0; i < 4; i++) begin
            fd0 = fd_cnt; se0 = se_cnt; cs0 = cs_ticks;
            send_frame(vecs[i].data, vecs[i].stop, -1);
            ticks(8, 1'b1);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_stop_sample", i), last_stop, vecs[i].exp_stop);
            check($sformatf("vec%0d_frame_done", i), fd_cnt - fd0, 1);
            check($sformatf("vec%0d_stop_window", i), cs_ticks - cs0, 16);
            check($sformatf("vec%0d_start_error", i), se_cnt - se0, vecs[i].exp_se);
            check($sformatf("vec%0d_idle", i), rx_busy, 0);
        end

        // Short low glitch on an idle line
        fd0 = fd_cnt; se0 = se_cnt;
        ticks(3, 1'b0);
        ticks(14, 1'b1);
        check("glitch_start_error", se_cnt - se0, 1);
        check("glitch_idle", rx_busy, 0);
        check("glitch_rx_data", rx_data, 8'h01);
        check("glitch_no_frame", fd_cnt - fd0, 0);

        // Back-to-back frames, no idle gap
        fd0 = fd_cnt; se0 = se_cnt;
        send_frame(8'h00, 1'b1, -1);
        check("b2b_first_data", last_data, 8'h00);
        send_frame(8'hFF, 1'b1, -1);
        ticks(8, 1'b1);
        check("b2b_second_data", last_data, 8'hFF);
        check("b2b_frames", fd_cnt - fd0, 2);
        check("b2b_start_error", se_cnt - se0, 0);

        // Reset during data bit 4 of 0x5A
        fd0 = fd_cnt;
        ticks(16, 1'b0);
        ticks(16, 1'b0);
        ticks(16, 1'b1);
        ticks(16, 1'b0);
        ticks(16, 1'b1);
        ticks(8, 1'b1);
        check("pre_rst_busy", rx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_stop_sample", stop_sample, 0);
        check("mid_rst_check_stop", check_stop, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_start_error", start_error, 0);
        check("mid_rst_busy", rx_busy, 0);
        rx_line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ticks(4, 1'b1);
        send_frame(8'h81, 1'b1, -1);
        ticks(8, 1'b1);
        check("post_rst_rx_data", rx_data, 8'h81);
        check("post_rst_stop_sample", stop_sample, 1);
        check("post_rst_frames", fd_cnt - fd0, 1);

        // Tick stream stalls for 50 clocks in the middle of data bit 2
        fd0 = fd_cnt;
        send_frame(8'h96, 1'b1, 60);
        ticks(8, 1'b1);
        check("gap_rx_data", rx_data, 8'h96);
        check("gap_frames", fd_cnt - fd0, 1);

        check("rx_data_stable_in_window", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
